// File: rtl/ram_wait_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_pkg: access-size codes, FSM state encoding and size helper       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ram_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of byte lanes touched by an access; illegal size touches none.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_wait_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_wait_ctrl_if: MOV/MOC request/complete bus of the wait-state RAM |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface ram_wait_ctrl_if #(
  parameter int AW = 8
);
  logic          MOV;
  logic          RW;
  logic [AW-1:0] ADDR;
  logic [31:0]   DATA_IN;
  logic [1:0]    typeData;
  logic [31:0]   DATA_OUT;
  logic          MOC;
  logic          ERR;

  modport master (
    output MOV, RW, ADDR, DATA_IN, typeData,
    input  DATA_OUT, MOC, ERR
  );

  modport slave (
    input  MOV, RW, ADDR, DATA_IN, typeData,
    output DATA_OUT, MOC, ERR
  );
endinterface
`default_nettype wire

// File: rtl/ram_lane_steer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_lane_steer: byte-lane addresses/enables and access error flag    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ram_lane_steer
  import ram_pkg::*;
#(
  parameter int AW          = 8,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic [AW-1:0]       addr,
  input  logic [1:0]          size,
  output logic [3:0][AW-1:0]  lane_addr,
  output logic [3:0]          lane_en,
  output logic                err
);

  // Lane 0 is the most significant byte; AW-bit addition wraps modulo DEPTH.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane_addr[i] = addr + AW'(i);
    assign lane_en[i]   = (3'(i) < size_bytes(size));
  end

  always_comb begin
    err = 1'b0;
    if (size == SIZE_ILL) begin
      err = 1'b1;
    end else if (ALIGN_CHECK) begin
      if (size == SIZE_HALF && addr[0])
        err = 1'b1;
      if (size == SIZE_WORD && addr[1:0] != 2'b00)
        err = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_wait_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_wait_ctrl: byte-addressed big-endian RAM, MOV/MOC handshake with |
// | programmable wait states, alignment checking and abort-on-drop       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ram_wait_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int AW          = $clog2(DEPTH),
  parameter int WAIT_CYCLES = 2,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic           CLK,
  input  logic           CLR,
  ram_wait_ctrl_if.slave bus
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

  logic [7:0] mem [0:DEPTH-1];

  state_t         r_state, w_state_next;
  logic [3:0]     r_cnt;
  logic           r_rw;
  logic [AW-1:0]  r_addr;
  logic [31:0]    r_din;
  logic [1:0]     r_size;
  logic           r_err;
  logic [31:0]    r_dout;

  logic              w_capture, w_access, w_we;
  logic              w_rw, w_err;
  logic [AW-1:0]     w_addr;
  logic [1:0]        w_size;
  logic [31:0]       w_din, w_rdata;
  logic [3:0][AW-1:0] w_lane_addr;
  logic [3:0]        w_lane_en;
  logic [3:0][7:0]   w_rb, w_wb;

  // A zero-wait access completes on the capture edge, so it uses live inputs.
  assign w_rw   = (r_state == IDLE) ? bus.RW       : r_rw;
  assign w_addr = (r_state == IDLE) ? bus.ADDR     : r_addr;
  assign w_din  = (r_state == IDLE) ? bus.DATA_IN  : r_din;
  assign w_size = (r_state == IDLE) ? bus.typeData : r_size;

  ram_lane_steer #(
    .AW          (AW),
    .ALIGN_CHECK (ALIGN_CHECK)
  ) u_steer (
    .addr      (w_addr),
    .size      (w_size),
    .lane_addr (w_lane_addr),
    .lane_en   (w_lane_en),
    .err       (w_err)
  );

  always_ff @(posedge CLK) begin
    if (!CLR) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_access     = 1'b0;
    case (r_state)
      IDLE: if (bus.MOV) begin
        w_capture = 1'b1;
        if (NO_WAIT) begin
          w_access     = 1'b1;
          w_state_next = DONE;
        end else begin
          w_state_next = BUSY;
        end
      end
      BUSY: if (!bus.MOV) begin
        w_state_next = IDLE;
      end else if (r_cnt == 4'd1) begin
        w_access     = 1'b1;
        w_state_next = DONE;
      end
      DONE: if (!bus.MOV) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_we = w_access && !w_rw && !w_err;

  always_comb begin
    w_wb = '0;
    for (int i = 0; i < 4; i++)
      w_rb[i] = w_lane_en[i] ? mem[w_lane_addr[i]] : 8'h00;
    case (w_size)
      SIZE_BYTE: begin
        w_rdata = {24'h0, w_rb[0]};
        w_wb[0] = w_din[7:0];
      end
      SIZE_HALF: begin
        w_rdata = {16'h0, w_rb[0], w_rb[1]};
        w_wb[0] = w_din[15:8];
        w_wb[1] = w_din[7:0];
      end
      SIZE_WORD: begin
        w_rdata = {w_rb[0], w_rb[1], w_rb[2], w_rb[3]};
        w_wb    = {w_din[7:0], w_din[15:8], w_din[23:16], w_din[31:24]};
      end
      default: w_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      r_cnt  <= 4'd0;
      r_rw   <= 1'b0;
      r_addr <= '0;
      r_din  <= 32'h0;
      r_size <= 2'b00;
      r_err  <= 1'b0;
      r_dout <= 32'h0;
    end else begin
      if (w_capture) begin
        r_cnt  <= WAIT_INIT;
        r_rw   <= bus.RW;
        r_addr <= bus.ADDR;
        r_din  <= bus.DATA_IN;
        r_size <= bus.typeData;
      end else if (r_state == BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_err  <= w_err;
        r_dout <= (w_rw && !w_err) ? w_rdata : 32'h0;
      end
    end
  end

  // Storage is not reset; a reset edge suppresses any pending write.
  always_ff @(posedge CLK) begin
    if (CLR && w_we) begin
      for (int i = 0; i < 4; i++)
        if (w_lane_en[i]) mem[w_lane_addr[i]] <= w_wb[i];
    end
  end

  assign bus.MOC      = (r_state == DONE);
  assign bus.ERR      = r_err;
  assign bus.DATA_OUT = r_dout;

endmodule
`default_nettype wire
